// File: rtl/tmp_decim.sv
// tmp_decim: decimating counter for the temperature-sensor charge-balance loop.
// Each src_n / snk toggle is one charge packet. Over a window of 2^OSR_LOG2
// packets the number of source packets is counted and published as a
// temperature code on a valid/ready handshake.
module tmp_decim #(
  parameter int OSR_LOG2   = 8,
  parameter int CODE_W     = OSR_LOG2 + 1,
  parameter int TIMEOUT    = 1023,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              src_n,
  input  logic              snk,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              busy,
  output logic              ovf,
  output logic              timeout_err
);

  // Packet counters must hold 0..N inclusive.
  localparam int CNT_W  = OSR_LOG2 + 1;
  localparam int IDLE_W = 10;

  localparam logic [CNT_W-1:0]  N_VAL     = {1'b1, {OSR_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0]  N_M1      = N_VAL - 1'b1;
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               src_q, src_d;
  logic               snk_q, snk_d;
  logic [CNT_W-1:0]   src_cnt_q, src_cnt_d;
  logic [CNT_W-1:0]   tot_cnt_q, tot_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               code_valid_q, code_valid_d;
  logic               ovf_q, ovf_d;
  logic               timeout_err_q, timeout_err_d;

  // Per-cycle packet decode
  logic               src_tog;
  logic               snk_tog;
  logic               any_tog;
  logic               src_cnt_en;
  logic               snk_cnt_en;
  logic [CNT_W-1:0]   src_cnt_next;
  logic [CNT_W-1:0]   tot_cnt_next;
  logic [IDLE_W-1:0]  idle_cnt_inc;

  // Toggle detection against last cycle's line levels.
  assign src_tog = src_n ^ src_q;
  assign snk_tog = snk ^ snk_q;
  assign any_tog = src_tog | snk_tog;

  // Next-state, counter and handshake logic.
  always_comb begin
    state_d       = state_q;
    src_d         = src_n;
    snk_d         = snk;
    src_cnt_d     = src_cnt_q;
    tot_cnt_d     = tot_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    code_d        = code_q;
    code_valid_d  = code_valid_q;
    ovf_d         = ovf_q;
    timeout_err_d = timeout_err_q;

    src_cnt_en    = 1'b0;
    snk_cnt_en    = 1'b0;
    src_cnt_next  = src_cnt_q;
    tot_cnt_next  = tot_cnt_q;
    idle_cnt_inc  = idle_cnt_q + 1'b1;

    // A transfer drops valid; a completion below may re-raise it.
    if (code_valid_q && out_ready) begin
      code_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_SYNC;
          src_cnt_d     = '0;
          tot_cnt_d     = '0;
          idle_cnt_d    = '0;
          ovf_d         = 1'b0;
          timeout_err_d = 1'b0;
        end
      end

      // One cycle to let the toggle history settle; nothing is counted.
      ST_SYNC: begin
        state_d = ST_ACCUM;
      end

      ST_ACCUM: begin
        // On the last slot of a window only one packet fits, and the
        // source packet takes precedence over a simultaneous sink packet.
        src_cnt_en   = src_tog;
        snk_cnt_en   = snk_tog && !(src_tog && (tot_cnt_q == N_M1));
        src_cnt_next = src_cnt_q + CNT_W'(src_cnt_en);
        tot_cnt_next = tot_cnt_q + CNT_W'(src_cnt_en) + CNT_W'(snk_cnt_en);

        if (tot_cnt_next == N_VAL) begin
          // Window complete: publish unless an unaccepted code is pending.
          if (!code_valid_q || out_ready) begin
            code_d       = CODE_W'(src_cnt_next);
            code_valid_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          src_cnt_d  = '0;
          tot_cnt_d  = '0;
          idle_cnt_d = '0;
          state_d    = CONTINUOUS ? ST_SYNC : ST_IDLE;
        end else if (!any_tog && (idle_cnt_inc == TIMEOUT_V)) begin
          // Controller went quiet for too long: abandon the window.
          timeout_err_d = 1'b1;
          src_cnt_d     = '0;
          tot_cnt_d     = '0;
          idle_cnt_d    = '0;
          state_d       = ST_IDLE;
        end else begin
          src_cnt_d  = src_cnt_next;
          tot_cnt_d  = tot_cnt_next;
          idle_cnt_d = any_tog ? '0 : idle_cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      src_q         <= 1'b0;
      snk_q         <= 1'b0;
      src_cnt_q     <= '0;
      tot_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      code_q        <= '0;
      code_valid_q  <= 1'b0;
      ovf_q         <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      snk_q         <= snk_d;
      src_cnt_q     <= src_cnt_d;
      tot_cnt_q     <= tot_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      code_q        <= code_d;
      code_valid_q  <= code_valid_d;
      ovf_q         <= ovf_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign code        = code_q;
  assign code_valid  = code_valid_q;
  assign busy        = (state_q == ST_SYNC) || (state_q == ST_ACCUM);
  assign ovf         = ovf_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tmp_decim.sv
// tb_tmp_decim: directed bench for tmp_decim with N=16 and TIMEOUT=31.
// One instance runs single-shot, a second runs in continuous mode; they
// share the toggle lines and reset but have their own start/out_ready.
module tb_tmp_decim;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, start_c;
  logic       src_n, snk;
  logic       out_ready, out_ready_c;
  logic [4:0] code, code_c;
  logic       code_valid, code_valid_c;
  logic       busy, busy_c;
  logic       ovf, ovf_c;
  logic       timeout_err, timeout_err_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tmp_decim #(.OSR_LOG2(4), .CODE_W(5), .TIMEOUT(31), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_n(src_n), .snk(snk),
    .out_ready(out_ready), .code(code), .code_valid(code_valid), .busy(busy),
    .ovf(ovf), .timeout_err(timeout_err)
  );

  tmp_decim #(.OSR_LOG2(4), .CODE_W(5), .TIMEOUT(31), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .src_n(src_n), .snk(snk),
    .out_ready(out_ready_c), .code(code_c), .code_valid(code_valid_c), .busy(busy_c),
    .ovf(ovf_c), .timeout_err(timeout_err_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("chk  %s: got=%0d", tag, got);
    end
  endtask

  // Interleaved packets, each followed by one quiet cycle.
  task automatic send(input int nsrc, input int nsnk);
    int s = nsrc;
    int k = nsnk;
    bit pick = 1'b1;
    while (s > 0 || k > 0) begin
      if ((pick && s > 0) || k == 0) begin
        src_n = ~src_n;
        s--;
      end else begin
        snk = ~snk;
        k--;
      end
      pick = ~pick;
      tick();
      tick();
    end
  endtask

  // Start the single-shot instance and wait out its SYNC cycle.
  task automatic begin_win;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic accept;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    start_c     = 1'b0;
    src_n       = 1'b0;
    snk         = 1'b0;
    out_ready   = 1'b0;
    out_ready_c = 1'b0;
    tick();
    tick();
    check_val("rst_code",  32'(code), 32'd0);
    check_val("rst_valid", 32'(code_valid), 32'd0);
    check_val("rst_busy",  32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic window: 10 src + 6 snk, result one cycle after the 16th packet.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_busy", 32'(busy), 32'd1);
    tick();
    send(10, 5);
    check_val("pre_valid", 32'(code_valid), 32'd0);
    check_val("pre_busy",  32'(busy), 32'd1);
    snk = ~snk;
    tick();
    check_val("basic_valid", 32'(code_valid), 32'd1);
    check_val("basic_code",  32'(code), 32'd10);
    check_val("basic_busy",  32'(busy), 32'd0);

    // Handshake: code held while out_ready is low.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("hold_code", 32'(code), 32'd10);
    end
    check_val("hold_valid", 32'(code_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("acc_valid", 32'(code_valid), 32'd0);

    // Reset in the middle of a window after 7 packets.
    begin_win();
    send(4, 3);
    check_val("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("arst_code",  32'(code), 32'd0);
    check_val("arst_valid", 32'(code_valid), 32'd0);
    check_val("arst_busy",  32'(busy), 32'd0);
    check_val("arst_ovf",   32'(ovf), 32'd0);
    check_val("arst_terr",  32'(timeout_err), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Fresh start after reset: all-source window gives N.
    begin_win();
    send(15, 0);
    src_n = ~src_n;
    tick();
    check_val("allsrc_valid", 32'(code_valid), 32'd1);
    check_val("allsrc_code",  32'(code), 32'd16);
    accept();

    // Both toggles on the last slot: only the source packet counts.
    begin_win();
    send(5, 10);
    src_n = ~src_n;
    snk   = ~snk;
    tick();
    check_val("both_valid", 32'(code_valid), 32'd1);
    check_val("both_code",  32'(code), 32'd6);
    check_val("both_ovf",   32'(ovf), 32'd0);
    accept();

    // All-sink window gives 0.
    begin_win();
    send(0, 15);
    snk = ~snk;
    tick();
    check_val("allsnk_valid", 32'(code_valid), 32'd1);
    check_val("allsnk_code",  32'(code), 32'd0);
    accept();

    // Continuous instance: overflow, then simultaneous accept + completion.
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    tick();
    send(3, 12);
    snk = ~snk;
    tick();
    check_val("w1_code",  32'(code_c), 32'd3);
    check_val("w1_valid", 32'(code_valid_c), 32'd1);
    check_val("w1_ovf",   32'(ovf_c), 32'd0);
    check_val("w1_busy",  32'(busy_c), 32'd1);
    tick();
    send(7, 8);
    src_n = ~src_n;
    tick();
    check_val("w2_ovf",   32'(ovf_c), 32'd1);
    check_val("w2_code",  32'(code_c), 32'd3);
    check_val("w2_valid", 32'(code_valid_c), 32'd1);
    tick();
    send(11, 4);
    src_n = ~src_n;
    out_ready_c = 1'b1;
    tick();
    out_ready_c = 1'b0;
    check_val("w3_code",  32'(code_c), 32'd12);
    check_val("w3_valid", 32'(code_valid_c), 32'd1);
    check_val("w3_ovf",   32'(ovf_c), 32'd1);
    check_val("single_idle", 32'(busy), 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Timeout: five packets, then silence until idle_cnt reaches 31.
    begin_win();
    send(3, 2);
    repeat (29) tick();
    check_val("to_early_err",  32'(timeout_err), 32'd0);
    check_val("to_early_busy", 32'(busy), 32'd1);
    tick();
    check_val("to_err",   32'(timeout_err), 32'd1);
    check_val("to_busy",  32'(busy), 32'd0);
    check_val("to_valid", 32'(code_valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("to_clear", 32'(timeout_err), 32'd0);
    check_val("to_restart_busy", 32'(busy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
